// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline sequencing controller for the 5-stage RISC-V core.
// Inserts one bubble per load-use hazard, freezes the pipe during data memory
// waits, flushes wrong-path instructions after a redirect, counts stall cycles
// and raises a sticky flag when a memory access waits too long.
module hazard_stall_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       IF_ID_opcode_ip,
    input  logic [4:0]       IF_ID_rs1_ip,
    input  logic [4:0]       IF_ID_rs2_ip,
    input  logic             ID_EX_mem_read_ip,
    input  logic [4:0]       ID_EX_dest_ip,
    input  logic             branch_taken_ip,
    input  logic             dmem_req_ip,
    input  logic             dmem_ready_ip,
    output logic             pc_stall_op,
    output logic             if_id_stall_op,
    output logic             id_ex_bubble_op,
    output logic             if_id_flush_op,
    output logic             id_ex_flush_op,
    output logic             ex_mem_stall_op,
    output logic             mem_wb_bubble_op,
    output logic [CNT_W-1:0] stall_cnt_op,
    output logic             timeout_err_op
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam int FC_W   = 2;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    state_t            state_q;
    state_t            w_stateNext;
    logic [FC_W-1:0]   r_flushCnt;
    logic [FC_W-1:0]   w_flushCntNext;
    logic [WAIT_W-1:0] r_waitCnt;

    logic w_rs1Used;
    logic w_rs2Used;
    logic w_loadUse;
    logic w_memWait;
    logic w_memStall;
    logic w_luStall;
    logic w_flush;

    // Which source registers the decode instruction actually reads
    always_comb begin
        w_rs1Used = 1'b0;
        w_rs2Used = 1'b0;
        case (IF_ID_opcode_ip)
            OPC_OP, OPC_STORE, OPC_BRANCH: begin
                w_rs1Used = 1'b1;
                w_rs2Used = 1'b1;
            end
            OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
                w_rs1Used = 1'b1;
            end
            default: begin
                w_rs1Used = 1'b0;
                w_rs2Used = 1'b0;
            end
        endcase
    end

    assign w_loadUse = ID_EX_mem_read_ip && (ID_EX_dest_ip != 5'd0) &&
                       ((w_rs1Used && (IF_ID_rs1_ip == ID_EX_dest_ip)) ||
                        (w_rs2Used && (IF_ID_rs2_ip == ID_EX_dest_ip)));
    assign w_memWait = dmem_req_ip & ~dmem_ready_ip;

    // Next-state and action selection; memory wait beats redirect beats load-use
    always_comb begin
        w_stateNext    = state_q;
        w_flushCntNext = r_flushCnt;
        w_memStall     = 1'b0;
        w_luStall      = 1'b0;
        w_flush        = 1'b0;
        case (state_q)
            RUN, LU_STALL: begin
                if (w_memWait) begin
                    w_memStall  = 1'b1;
                    w_stateNext = MEM_WAIT;
                end else if (branch_taken_ip) begin
                    w_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_stateNext    = FLUSH;
                        w_flushCntNext = FC_W'(FLUSH_CYCLES - 1);
                    end else begin
                        w_stateNext = RUN;
                    end
                end else if ((state_q == RUN) && w_loadUse) begin
                    w_luStall   = 1'b1;
                    w_stateNext = LU_STALL;
                end else begin
                    w_stateNext = RUN;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready_ip) begin
                    w_memStall = 1'b1;
                end else begin
                    w_stateNext = RUN;
                end
            end
            FLUSH: begin
                if (w_memWait) begin
                    w_memStall     = 1'b1;
                    w_stateNext    = MEM_WAIT;
                    w_flushCntNext = '0;
                end else begin
                    w_flush        = 1'b1;
                    w_flushCntNext = r_flushCnt - FC_W'(1);
                    if (r_flushCnt == FC_W'(1)) begin
                        w_stateNext = RUN;
                    end
                end
            end
            default: begin
                w_stateNext = RUN;
            end
        endcase
    end

    assign pc_stall_op      = ~reset & (w_memStall | w_luStall);
    assign if_id_stall_op   = ~reset & (w_memStall | w_luStall);
    assign id_ex_bubble_op  = ~reset & w_luStall;
    assign if_id_flush_op   = ~reset & w_flush;
    assign id_ex_flush_op   = ~reset & w_flush;
    assign ex_mem_stall_op  = ~reset & w_memStall;
    assign mem_wb_bubble_op = ~reset & w_memStall;

    // FSM state and remaining-flush counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            r_flushCnt <= '0;
        end else begin
            state_q    <= w_stateNext;
            r_flushCnt <= w_flushCntNext;
        end
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_op <= '0;
        end else if (pc_stall_op && (stall_cnt_op != {CNT_W{1'b1}})) begin
            stall_cnt_op <= stall_cnt_op + CNT_W'(1);
        end
    end

    // Length of the current memory-wait run and the sticky timeout flag it feeds
    always_ff @(posedge clk) begin
        if (reset) begin
            r_waitCnt      <= '0;
            timeout_err_op <= 1'b0;
        end else if (w_memStall) begin
            if (r_waitCnt != WAIT_W'(MEM_TIMEOUT)) begin
                r_waitCnt <= r_waitCnt + WAIT_W'(1);
            end
            if (r_waitCnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                timeout_err_op <= 1'b1;
            end
        end else begin
            r_waitCnt <= '0;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: drives the stall controller with directed scenarios and
// random traffic, predicting every cycle from a behavioural model of the rules.
module tb_hazard_stall_ctrl;

    localparam int FLUSH_N = 2;
    localparam int TIMEOUT = 64;
    localparam int SAT_MAX = 7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [6:0] opcode;
    logic [4:0] rs1, rs2, dest;
    logic       memRead, branch, dmemReq, dmemReady;

    logic        pcStall, ifIdStall, idExBubble, ifIdFlush, idExFlush, exMemStall, memWbBubble;
    logic [15:0] stallCnt;
    logic        timeoutErr;
    logic        sPcStall, sIfIdStall, sIdExBubble, sIfIdFlush, sIdExFlush, sExMemStall, sMemWbBubble;
    logic [2:0]  sStallCnt;
    logic        sTimeoutErr;

    hazard_stall_ctrl #(.FLUSH_CYCLES(FLUSH_N), .MEM_TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .IF_ID_opcode_ip(opcode), .IF_ID_rs1_ip(rs1), .IF_ID_rs2_ip(rs2),
        .ID_EX_mem_read_ip(memRead), .ID_EX_dest_ip(dest),
        .branch_taken_ip(branch), .dmem_req_ip(dmemReq), .dmem_ready_ip(dmemReady),
        .pc_stall_op(pcStall), .if_id_stall_op(ifIdStall), .id_ex_bubble_op(idExBubble),
        .if_id_flush_op(ifIdFlush), .id_ex_flush_op(idExFlush),
        .ex_mem_stall_op(exMemStall), .mem_wb_bubble_op(memWbBubble),
        .stall_cnt_op(stallCnt), .timeout_err_op(timeoutErr)
    );

    hazard_stall_ctrl #(.FLUSH_CYCLES(FLUSH_N), .MEM_TIMEOUT(TIMEOUT), .CNT_W(3)) dutSat (
        .clk(clk), .reset(reset),
        .IF_ID_opcode_ip(opcode), .IF_ID_rs1_ip(rs1), .IF_ID_rs2_ip(rs2),
        .ID_EX_mem_read_ip(memRead), .ID_EX_dest_ip(dest),
        .branch_taken_ip(branch), .dmem_req_ip(dmemReq), .dmem_ready_ip(dmemReady),
        .pc_stall_op(sPcStall), .if_id_stall_op(sIfIdStall), .id_ex_bubble_op(sIdExBubble),
        .if_id_flush_op(sIfIdFlush), .id_ex_flush_op(sIdExFlush),
        .ex_mem_stall_op(sExMemStall), .mem_wb_bubble_op(sMemWbBubble),
        .stall_cnt_op(sStallCnt), .timeout_err_op(sTimeoutErr)
    );

    int checks = 0;
    int passes = 0;

    // Behavioural model: what the pipeline is currently doing
    bit mInMem;
    bit mJustLu;
    int mFlushLeft;
    int mStallCnt;
    int mWaitRun;
    bit mErr;

    function automatic bit readsRs1(input logic [6:0] o);
        return (o == OP_OP) || (o == OP_OPIMM) || (o == OP_LOAD) ||
               (o == OP_STORE) || (o == OP_BRANCH) || (o == OP_JALR);
    endfunction

    function automatic bit readsRs2(input logic [6:0] o);
        return (o == OP_OP) || (o == OP_STORE) || (o == OP_BRANCH);
    endfunction

    function automatic bit isHazard(input logic [6:0] o, input logic [4:0] a, input logic [4:0] b,
                                    input logic mr, input logic [4:0] d);
        return mr && (d != 0) && ((readsRs1(o) && a == d) || (readsRs2(o) && b == d));
    endfunction

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    task automatic checkOutput(input logic [6:0] eVec);
        int satCnt;
        satCnt = (mStallCnt > SAT_MAX) ? SAT_MAX : mStallCnt;
        checkVal("ctl", {pcStall, ifIdStall, idExBubble, ifIdFlush, idExFlush, exMemStall, memWbBubble}, eVec);
        checkVal("stallCnt", stallCnt, mStallCnt);
        checkVal("timeoutErr", timeoutErr, mErr);
        checkVal("satCtl", {sPcStall, sIfIdStall, sIdExBubble, sIfIdFlush, sIdExFlush, sExMemStall, sMemWbBubble}, eVec);
        checkVal("satStallCnt", sStallCnt, satCnt);
        checkVal("satTimeoutErr", sTimeoutErr, mErr);
    endtask

    // One clock cycle: drive inputs, check the predicted outputs mid-cycle, advance the model
    task automatic applyStimulus(input logic rst, input logic [6:0] o, input logic [4:0] a,
                                 input logic [4:0] b, input logic mr, input logic [4:0] d,
                                 input logic br, input logic req, input logic rdy);
        bit memNow, flushNow, luNow;
        int nextFlush;
        reset = rst; opcode = o; rs1 = a; rs2 = b; memRead = mr; dest = d;
        branch = br; dmemReq = req; dmemReady = rdy;
        #2;
        if (rst) begin
            memNow = 0; flushNow = 0; luNow = 0;
        end else begin
            memNow   = mInMem ? !rdy : (req && !rdy);
            flushNow = !memNow && !mInMem && (mFlushLeft > 0 || br);
            luNow    = !memNow && !mInMem && mFlushLeft == 0 && !br && !mJustLu && isHazard(o, a, b, mr, d);
        end
        checkOutput({memNow | luNow, memNow | luNow, luNow, flushNow, flushNow, memNow, memNow});
        @(posedge clk);
        if (rst) begin
            mInMem = 0; mJustLu = 0; mFlushLeft = 0; mStallCnt = 0; mWaitRun = 0; mErr = 0;
        end else begin
            if ((memNow || luNow) && mStallCnt < 65535) mStallCnt++;
            mWaitRun = memNow ? mWaitRun + 1 : 0;
            if (mWaitRun >= TIMEOUT) mErr = 1;
            if (memNow) nextFlush = 0;
            else if (mFlushLeft > 0) nextFlush = mFlushLeft - 1;
            else if (br && !mInMem) nextFlush = FLUSH_N - 1;
            else nextFlush = 0;
            mFlushLeft = nextFlush;
            mInMem = memNow;
            mJustLu = luNow;
        end
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, OP_OP, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0);
    endtask

    task automatic pulseReset();
        applyStimulus(1, OP_OP, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0);
    endtask

    logic [6:0] opTable [9] = '{OP_LOAD, OP_OPIMM, OP_AUIPC, OP_STORE, OP_OP,
                                OP_LUI, OP_BRANCH, OP_JALR, OP_JAL};

    initial begin
        int k;
        logic [6:0] rOp;
        reset = 1; opcode = 0; rs1 = 0; rs2 = 0; memRead = 0; dest = 0;
        branch = 0; dmemReq = 0; dmemReady = 0;
        repeat (2) @(posedge clk);
        #1;
        mInMem = 0; mJustLu = 0; mFlushLeft = 0; mStallCnt = 0; mWaitRun = 0; mErr = 0;

        // LW x5 / ADD x6,x5,x7: one bubble, then nothing
        pulseReset();
        applyStimulus(0, OP_OP, 5'd5, 5'd7, 1, 5'd5, 0, 0, 0);
        checkVal("luStallLit", {pcStall, ifIdStall}, 2'b00);
        applyStimulus(0, OP_OP, 5'd5, 5'd7, 1, 5'd5, 0, 0, 0);
        checkVal("luCntLit", stallCnt, 32'd1);
        idle();

        // LUI x5 after LW x5, and LW x0 feeding ADD x6,x0,x0: no stall
        pulseReset();
        applyStimulus(0, OP_LUI, 5'd5, 5'd5, 1, 5'd5, 0, 0, 0);
        applyStimulus(0, OP_OP, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0);
        checkVal("noHazardCntLit", stallCnt, 32'd0);

        // Three memory wait cycles then ready
        pulseReset();
        repeat (3) applyStimulus(0, OP_OP, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0);
        applyStimulus(0, OP_OP, 5'd1, 5'd2, 0, 5'd0, 0, 1, 1);
        checkVal("memCntLit", stallCnt, 32'd3);
        idle();

        // Redirect with a load-use hazard in decode: two flush cycles, no bubble
        pulseReset();
        applyStimulus(0, OP_OP, 5'd5, 5'd7, 1, 5'd5, 1, 0, 0);
        applyStimulus(0, OP_OP, 5'd5, 5'd7, 1, 5'd5, 0, 0, 0);
        checkVal("flushCntLit", stallCnt, 32'd0);
        idle();

        // Memory timeout boundary, stickiness, and clear on reset
        pulseReset();
        repeat (TIMEOUT - 1) applyStimulus(0, OP_OP, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0);
        checkVal("errBeforeLit", timeoutErr, 32'd0);
        applyStimulus(0, OP_OP, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0);
        checkVal("errAtLit", timeoutErr, 32'd1);
        checkVal("errCntLit", stallCnt, 32'd64);
        applyStimulus(0, OP_OP, 5'd1, 5'd2, 0, 5'd0, 0, 1, 1);
        checkVal("errStickyLit", timeoutErr, 32'd1);
        pulseReset();
        checkVal("errClearLit", timeoutErr, 32'd0);
        checkVal("cntClearLit", stallCnt, 32'd0);

        // Reset in the middle of a load-use stall, then a fresh hazard
        applyStimulus(0, OP_OP, 5'd5, 5'd7, 1, 5'd5, 0, 0, 0);
        applyStimulus(1, OP_OP, 5'd5, 5'd7, 1, 5'd5, 0, 0, 0);
        applyStimulus(0, OP_OP, 5'd5, 5'd7, 1, 5'd5, 0, 0, 0);
        checkVal("rstLuCntLit", stallCnt, 32'd1);
        idle();

        // Reset in the middle of a memory wait, then a fresh hazard
        applyStimulus(0, OP_OP, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0);
        applyStimulus(1, OP_OP, 5'd1, 5'd2, 0, 5'd0, 0, 1, 0);
        applyStimulus(0, OP_STORE, 5'd3, 5'd9, 1, 5'd9, 0, 0, 0);
        checkVal("rstMemCntLit", stallCnt, 32'd1);
        idle();

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            k = $urandom_range(0, 9);
            if (k == 9) rOp = 7'($urandom);
            else rOp = opTable[k];
            applyStimulus(($urandom_range(0, 59) == 0), rOp,
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
